// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    LS_WAIT = 2'd2
  } state_t;

  localparam int   STARVE_MAX_DEF = 4;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;
endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto a single memory port with one
// outstanding transaction; LSU has priority, bounded by a fetch-starvation counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvld,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic        ls_gnt,
  output logic        ls_rvld,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_rvld,
  input  logic [31:0] mem_rdata
);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          kill;
  logic          win;

  always_comb begin
    state_nxt = state;
    win       = REQ_LS;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = if_addr;
    mem_wdata = '0;
    mem_be    = 4'hF;
    case (state)
      IDLE: if (if_req || ls_req) begin
        win     = (if_req && (!ls_req || starve_cnt == SMAX)) ? REQ_IF : REQ_LS;
        mem_req = 1'b1;
        if (win == REQ_IF) begin
          if_gnt    = 1'b1;
          state_nxt = IF_WAIT;
        end else begin
          ls_gnt    = 1'b1;
          mem_we    = ls_we;
          mem_addr  = ls_addr;
          mem_wdata = ls_wdata;
          mem_be    = ls_be;
          state_nxt = LS_WAIT;
        end
      end
      IF_WAIT, LS_WAIT: if (mem_rvld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Reset masks every handshake so nothing is granted while RST is high.
    if (RST) begin
      if_gnt    = 1'b0;
      ls_gnt    = 1'b0;
      mem_req   = 1'b0;
      state_nxt = IDLE;
    end
  end

  assign ls_rvld  = mem_rvld && state == LS_WAIT && !RST;
  assign if_rvld  = mem_rvld && state == IF_WAIT && !kill && !if_flush && !RST;
  assign ls_rdata = mem_rdata;
  assign if_rdata = mem_rdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      kill       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (if_gnt)
        starve_cnt <= '0;
      else if (ls_gnt && if_req && starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 1'b1;
      // kill marks the outstanding fetch as stale after a redirect.
      if (if_gnt)
        kill <= if_flush;
      else if (state == IF_WAIT && !mem_rvld)
        kill <= kill | if_flush;
      else
        kill <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;
  localparam int SM = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req, if_flush, ls_req, ls_we, mem_rvld;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_be;
  logic        if_gnt, if_rvld, ls_gnt, ls_rvld, mem_req, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvld(if_rvld), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_rvld(ls_rvld), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  // Model: who owns the single outstanding slot (0 none, 1 fetch, 2 LSU),
  // how many LSU wins the waiting fetch has suffered, and whether the fetch is stale.
  int owner = 0, starve = 0;
  bit stale = 0;
  bit last_ifg, last_lsg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit e_ifg, e_lsg, e_ifv, e_lsv;
    #2;
    e_ifg = 0; e_lsg = 0; e_ifv = 0; e_lsv = 0;
    if (!RST) begin
      if (owner == 0 && (if_req || ls_req)) begin
        if (if_req && (!ls_req || starve >= SM)) e_ifg = 1;
        else e_lsg = 1;
      end
      e_lsv = (owner == 2) && mem_rvld;
      e_ifv = (owner == 1) && mem_rvld && !stale && !if_flush;
    end
    chk("if_gnt", 32'(if_gnt), 32'(e_ifg));
    chk("ls_gnt", 32'(ls_gnt), 32'(e_lsg));
    chk("mem_req", 32'(mem_req), 32'(e_ifg | e_lsg));
    chk("if_rvld", 32'(if_rvld), 32'(e_ifv));
    chk("ls_rvld", 32'(ls_rvld), 32'(e_lsv));
    if (e_ifg) begin
      chk("mem_addr_if", mem_addr, if_addr);
      chk("mem_we_if", 32'(mem_we), 32'd0);
      chk("mem_be_if", 32'(mem_be), 32'hF);
    end
    if (e_lsg) begin
      chk("mem_addr_ls", mem_addr, ls_addr);
      chk("mem_we_ls", 32'(mem_we), 32'(ls_we));
      chk("mem_be_ls", 32'(mem_be), 32'(ls_be));
      if (ls_we) chk("mem_wdata", mem_wdata, ls_wdata);
    end
    if (e_ifv) chk("if_rdata", if_rdata, mem_rdata);
    if (e_lsv) chk("ls_rdata", ls_rdata, mem_rdata);
    last_ifg = e_ifg; last_lsg = e_lsg;
    if (RST) begin
      owner = 0; starve = 0; stale = 0;
    end else if (e_ifg) begin
      owner = 1; stale = if_flush; starve = 0;
    end else if (e_lsg) begin
      owner = 2;
      if (if_req && starve < SM) starve++;
    end else if (owner != 0 && mem_rvld) begin
      owner = 0; stale = 0;
    end else if (owner == 1) begin
      stale = stale | if_flush;
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle_in();
    if_req = 0; if_flush = 0; ls_req = 0; ls_we = 0; mem_rvld = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0; mem_rdata = 0;
  endtask

  initial begin
    int ifn, lsn;
    idle_in();
    RST = 1; if_req = 1; ls_req = 1;
    @(posedge CLK); #1;
    cycle(); cycle();
    RST = 0; idle_in();
    cycle();

    // Fetch with 2-cycle response
    if_req = 1; if_addr = 32'h100; cycle();
    if_req = 0; cycle();
    mem_rvld = 1; mem_rdata = 32'hDEADBEEF; #2;
    chk("sc1_if_rvld", 32'(if_rvld), 32'd1);
    chk("sc1_if_rdata", if_rdata, 32'hDEADBEEF);
    cycle(); mem_rvld = 0;

    // Starvation: LSU held continuously alongside a fetch
    if_req = 1; if_addr = 32'h200; ls_req = 1; ls_addr = 32'h3000; ls_be = 4'hF;
    ifn = 0; lsn = 0;
    for (int i = 0; i < 12; i++) begin
      mem_rvld = (owner != 0);
      cycle();
      if (last_lsg && ifn == 0) lsn++;
      if (last_ifg) begin ifn++; if_req = 0; end
    end
    chk("sc2_ls_before_if", 32'(lsn), 32'(SM));
    chk("sc2_if_count", 32'(ifn), 32'd1);
    idle_in(); mem_rvld = 1; cycle(); mem_rvld = 0; cycle();

    // Flush after fetch grant kills the response
    if_req = 1; if_addr = 32'h400; cycle();
    if_req = 0; if_flush = 1; cycle();
    if_flush = 0; mem_rvld = 1; mem_rdata = 32'h1234; #2;
    chk("sc3_if_rvld", 32'(if_rvld), 32'd0);
    cycle(); mem_rvld = 0;
    ls_req = 1; #2; chk("sc3_back_idle", 32'(ls_gnt), 32'd1);
    cycle(); ls_req = 0; mem_rvld = 1; cycle(); mem_rvld = 0;

    // LSU partial write
    ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h2000; ls_wdata = 32'hCAFE_F00D; #2;
    chk("sc4_mem_we", 32'(mem_we), 32'd1);
    chk("sc4_mem_be", 32'(mem_be), 32'h3);
    cycle(); idle_in();
    mem_rvld = 1; #2; chk("sc4_ls_rvld", 32'(ls_rvld), 32'd1);
    cycle(); mem_rvld = 0;

    // Reset during LS_WAIT then stray response
    ls_req = 1; ls_addr = 32'h40; cycle(); ls_req = 0;
    RST = 1; cycle(); RST = 0;
    mem_rvld = 1; #2; chk("sc5_ls_rvld", 32'(ls_rvld), 32'd0);
    cycle(); mem_rvld = 0;

    // Spurious response in IDLE
    mem_rvld = 1; mem_rdata = 32'h5555; cycle(); mem_rvld = 0; cycle();

    // Randomized traffic; requests hold until granted
    idle_in();
    for (int i = 0; i < 800; i++) begin
      if (!(if_req && !last_ifg)) begin
        if_req = ($urandom_range(0, 2) == 0); if_addr = $urandom;
      end
      if (!(ls_req && !last_lsg)) begin
        ls_req = ($urandom_range(0, 1) == 0); ls_we = $urandom_range(0, 1);
        ls_addr = $urandom; ls_wdata = $urandom; ls_be = 4'($urandom);
      end
      if_flush  = ($urandom_range(0, 7) == 0);
      mem_rvld  = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      RST       = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive LSU grants while a fetch is pending.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port if_req  input  1  fetch request (held until granted).
REQ-005 SHALL have port if_addr  input  32  fetch address.
REQ-006 SHALL have port if_flush  input  1  redirect; discards any in-flight fetch response.
REQ-007 SHALL have port if_gnt  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_rvld  output  1  fetch data valid.
REQ-009 SHALL have port if_rdata  output  32  fetch data.
REQ-010 SHALL have ports ls_req / ls_we / ls_addr / ls_wdata / ls_be  input  1/1/32/32/4  load-store request, write enable, address, write data, byte enables.
REQ-011 SHALL have ports ls_gnt / ls_rvld / ls_rdata  output  1/1/32  load-store accept, response valid (also write acknowledge), read data.
REQ-012 SHALL have ports mem_req / mem_we / mem_addr / mem_wdata / mem_be  output  1/1/32/32/4  shared memory port request.
REQ-013 SHALL have ports mem_rvld / mem_rdata  input  1/32  memory response valid and data.

Function
REQ-014 SHALL implement FSM states IDLE, IF_WAIT, LS_WAIT, with at most one outstanding memory transaction.
REQ-015 In IDLE with any request present, SHALL combinationally assert mem_req and exactly one of if_gnt / ls_gnt, driving the winner's fields onto mem_*; mem_we=0 for fetches, mem_be=4'hF for fetches.
REQ-016 Arbitration SHALL give priority to LSU, except that when starve_cnt==STARVE_MAX and if_req=1 the fetch SHALL win.
REQ-017 starve_cnt SHALL increment on each ls_gnt while if_req=1, saturate at STARVE_MAX, and clear on every if_gnt.
REQ-018 Granted transitions SHALL be IDLE->IF_WAIT (if_gnt) and IDLE->LS_WAIT (ls_gnt); IDLE SHALL be held when there is no request.
REQ-019 In a WAIT state, mem_req, if_gnt and ls_gnt SHALL be 0; on mem_rvld=1 the FSM SHALL return to IDLE, so the next grant comes no earlier than the following cycle.
REQ-020 ls_rvld SHALL equal mem_rvld & (state==LS_WAIT); ls_rdata SHALL pass mem_rdata through combinationally; writes also complete via ls_rvld.
REQ-021 if_rvld SHALL equal mem_rvld & (state==IF_WAIT) & ~kill & ~if_flush; if_rdata SHALL pass mem_rdata through combinationally.
REQ-022 kill SHALL set on if_flush in IF_WAIT, or on if_flush coinciding with if_gnt, and SHALL clear when the FSM leaves IF_WAIT.
REQ-023 if_flush in IDLE or LS_WAIT with no fetch granted that cycle SHALL have no effect.
REQ-024 mem_rvld in IDLE SHALL be ignored, with no output pulse.
REQ-025 Minimum latency SHALL be: grant in cycle N, earliest response N+1, with *_rvld in the same cycle as mem_rvld.

Reset
REQ-026 While RST=1 at a clock edge: state=IDLE, starve_cnt=0, kill=0.
REQ-027 While RST=1, all grant, valid and mem_req outputs SHALL be 0 regardless of requests.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction, and a mem_rvld arriving after reset SHALL be ignored.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the FSM state encoding, the default STARVE_MAX and the requester ID constants (REQ_IF, REQ_LS).
REQ-030 The block SHALL be a single module with no sub-module; the starvation counter stays inline.

Verification
REQ-031 Scenario: if_req only, if_addr=0x100, mem_rvld 2 cycles later with rdata=0xDEADBEEF -> if_gnt in cycle 0, if_rvld=1 with if_rdata=0xDEADBEEF in cycle 2.
REQ-032 Scenario: if_req and ls_req both held, ls_req continuous, STARVE_MAX=4 -> 4 ls_gnt, then 1 if_gnt, then LSU again.
REQ-033 Scenario: fetch granted, if_flush one cycle later, mem_rvld next cycle -> if_rvld stays 0 and the FSM returns to IDLE.
REQ-034 Scenario: LSU write ls_we=1, ls_be=4'b0011, addr 0x2000 -> mem_we=1, mem_be=4'b0011, and ls_rvld on mem_rvld.
REQ-035 Scenario: RST=1 during LS_WAIT, then release, then a stray mem_rvld -> no ls_rvld, state=IDLE.
REQ-036 Scenario: spurious mem_rvld in IDLE -> no if_rvld and no ls_rvld.
